// File: rtl/round_seq_pkg.sv
// Shared types and constants for the requantisation/rounding sequencer.
package round_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_ERR,
        ST_DONE
    } state_t;

    localparam logic [1:0] RND_TRUNC   = 2'd0;
    localparam logic [1:0] RND_NEAREST = 2'd1;
    localparam int         LAT_MAX     = 4;

    // Modes 2 and 3 are reserved and behave as round-to-nearest.
    function automatic logic [1:0] norm_round(input logic [1:0] mode);
        return (mode == RND_TRUNC) ? RND_TRUNC : RND_NEAREST;
    endfunction

endpackage

// File: rtl/round_seq_delay.sv
// Single-bit delay line aligning the read strobe with rounded data.
module round_seq_delay #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sr <= '0;
        else          sr <= (sr << 1) | DEPTH'(i_d);
    end

    assign o_q = sr[DEPTH-1];

endmodule

// File: rtl/round_seq_ctrl.sv
// Job sequencer for the 32-lane 16b->8b rounding datapath: config latch,
// credit-gated row reads and latency-aligned output writes.
//
// state  | meaning
// IDLE   | waiting for i_start
// SETTLE | 2 cycles for the datapath shift amount to register
// RUN    | issuing row reads while credits allow
// DRAIN  | waiting for in-flight rows to be written
// ERR    | illegal Q config, nothing issued
// DONE   | one-cycle o_done pulse
module round_seq_ctrl
    import round_seq_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int CNT_W       = 16,
    parameter int RD_LAT      = 1,
    parameter int RND_LAT     = 1,
    parameter int OUT_CREDITS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_row_num,
    input  logic [ADDR_W-1:0] i_src_base,
    input  logic [ADDR_W-1:0] i_dst_base,
    input  logic [3:0]        i_q_enc,
    input  logic [3:0]        i_w_q_enc,
    input  logic [3:0]        i_o_q_enc,
    input  logic [1:0]        i_round_mode,
    input  logic              i_shift_en,
    input  logic              i_credit_ret,
    output logic [3:0]        o_q_enc,
    output logic [3:0]        o_w_q_enc,
    output logic [3:0]        o_o_q_enc,
    output logic [1:0]        o_round_mode,
    output logic              o_shift_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err,
    output logic              o_aborted
);

    localparam int DLY = RD_LAT + RND_LAT;

    state_t            state_q, state_d;
    logic              settle_q;
    logic [ADDR_W-1:0] src_base_q, dst_base_q;
    logic [CNT_W-1:0]  row_q, issued_q, written_q;
    logic [3:0]        inflight_q;
    logic [3:0]        credits_q;
    logic [4:0]        cred_sum;
    logic              abort_q, err_q;
    logic              start_ok, rd_en, wr_en, cfg_bad;

    assign cfg_bad = ({1'b0, i_q_enc} + {1'b0, i_w_q_enc}) < {1'b0, i_o_q_enc};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        rd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    start_ok = 1'b1;
                    if (cfg_bad)             state_d = ST_ERR;
                    else if (i_row_num == '0) state_d = ST_DONE;
                    else                     state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: if (!settle_q) state_d = ST_RUN;
            ST_RUN: begin
                rd_en = (issued_q < row_q) && (credits_q != '0) && !i_abort;
                if ((issued_q == row_q) || i_abort) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (inflight_q == '0) state_d = ST_DONE;
            ST_ERR:   state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q_enc      <= '0;
            o_w_q_enc    <= '0;
            o_o_q_enc    <= '0;
            o_round_mode <= '0;
            o_shift_en   <= 1'b0;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            row_q        <= '0;
            err_q        <= 1'b0;
        end else if (start_ok) begin
            o_q_enc      <= i_q_enc;
            o_w_q_enc    <= i_w_q_enc;
            o_o_q_enc    <= i_o_q_enc;
            o_round_mode <= norm_round(i_round_mode);
            o_shift_en   <= i_shift_en;
            src_base_q   <= i_src_base;
            dst_base_q   <= i_dst_base;
            row_q        <= i_row_num;
            err_q        <= cfg_bad;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            settle_q  <= 1'b0;
            issued_q  <= '0;
            written_q <= '0;
            abort_q   <= 1'b0;
        end else if (start_ok) begin
            settle_q  <= 1'b1;
            issued_q  <= '0;
            written_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            if (state_q == ST_SETTLE) settle_q <= 1'b0;
            if (rd_en)                issued_q <= issued_q + 1'b1;
            if (wr_en)                written_q <= written_q + 1'b1;
            if (state_q == ST_RUN && i_abort) abort_q <= 1'b1;
        end
    end

    // Credits persist across jobs; returns beyond the slot count are dropped.
    assign cred_sum = {1'b0, credits_q} + 5'(i_credit_ret) - 5'(rd_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_q  <= 4'(OUT_CREDITS);
            inflight_q <= '0;
        end else begin
            credits_q  <= (cred_sum > 5'(OUT_CREDITS)) ? 4'(OUT_CREDITS) : cred_sum[3:0];
            inflight_q <= inflight_q + 4'(rd_en) - 4'(wr_en);
        end
    end

    round_seq_delay #(.DEPTH(DLY)) u_wr_align (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (rd_en),
        .o_q     (wr_en)
    );

    assign o_rd_en   = rd_en;
    assign o_rd_addr = src_base_q + ADDR_W'(issued_q);
    assign o_wr_en   = wr_en;
    assign o_wr_addr = dst_base_q + ADDR_W'(written_q);
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = (state_q == ST_DONE);
    assign o_cfg_err = (state_q == ST_DONE) && err_q;
    assign o_aborted = (state_q == ST_DONE) && abort_q;

endmodule

// File: tb/tb_round_seq_ctrl.sv
// Directed self-checking bench for round_seq_ctrl.
module tb_round_seq_ctrl;
    import round_seq_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0, i_abort = 1'b0, i_shift_en = 1'b0, i_credit_ret = 1'b0;
    logic [15:0] i_row_num = '0;
    logic [11:0] i_src_base = '0, i_dst_base = '0;
    logic [3:0]  i_q_enc = '0, i_w_q_enc = '0, i_o_q_enc = '0;
    logic [1:0]  i_round_mode = '0;
    logic [3:0]  o_q_enc, o_w_q_enc, o_o_q_enc;
    logic [1:0]  o_round_mode;
    logic        o_shift_en, o_rd_en, o_wr_en, o_busy, o_done, o_cfg_err, o_aborted;
    logic [11:0] o_rd_addr, o_wr_addr;

    round_seq_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_row_num(i_row_num), .i_src_base(i_src_base), .i_dst_base(i_dst_base),
        .i_q_enc(i_q_enc), .i_w_q_enc(i_w_q_enc), .i_o_q_enc(i_o_q_enc),
        .i_round_mode(i_round_mode), .i_shift_en(i_shift_en), .i_credit_ret(i_credit_ret),
        .o_q_enc(o_q_enc), .o_w_q_enc(o_w_q_enc), .o_o_q_enc(o_o_q_enc),
        .o_round_mode(o_round_mode), .o_shift_en(o_shift_en),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err), .o_aborted(o_aborted)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;
    int cyc = 0, done_n = 0, done_cyc = -1, cfg_chg = 0;
    logic err_at_done = 1'b0, ab_at_done = 1'b0;
    logic [14:0] cfg_exp = '0;
    int rd_cyc[$], wr_cyc[$];
    logic [11:0] rd_addr_q[$], wr_addr_q[$];
    int exp_stall[10] = '{3, 4, 5, 6, 21, 24, 25, 26, 27, 28};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {19'd0, o_q_enc, o_w_q_enc, o_o_q_enc, o_round_mode, o_shift_en, o_rd_en,
                o_rd_addr, o_wr_en, o_wr_addr, o_busy, o_done, o_cfg_err, o_aborted};
    endfunction

    // Sample the current cycle mid-period, then advance to just after the next edge.
    task automatic step();
        #3;
        if (o_rd_en) begin rd_cyc.push_back(cyc); rd_addr_q.push_back(o_rd_addr); end
        if (o_wr_en) begin wr_cyc.push_back(cyc); wr_addr_q.push_back(o_wr_addr); end
        if (o_done) begin
            done_n++; done_cyc = cyc; err_at_done = o_cfg_err; ab_at_done = o_aborted;
        end
        if (o_busy && ({o_q_enc, o_w_q_enc, o_o_q_enc, o_round_mode, o_shift_en} != cfg_exp))
            cfg_chg++;
        @(posedge i_clk); #1;
        cyc++;
    endtask

    task automatic start_job(input logic [3:0] q, input logic [3:0] w, input logic [3:0] o,
                             input logic [1:0] rm, input logic sh, input logic [15:0] rows,
                             input logic [11:0] src, input logic [11:0] dst);
        i_q_enc = q; i_w_q_enc = w; i_o_q_enc = o; i_round_mode = rm; i_shift_en = sh;
        i_row_num = rows; i_src_base = src; i_dst_base = dst; i_start = 1'b1;
        cfg_exp = {q, w, o, (rm == 2'd0) ? 2'd0 : 2'd1, sh};
        rd_cyc.delete(); wr_cyc.delete(); rd_addr_q.delete(); wr_addr_q.delete();
        done_n = 0; done_cyc = -1; cfg_chg = 0; cyc = 0;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (done_n == 0 && k < limit) begin step(); k++; end
        chk({tag, "_done_seen"}, 64'(done_n != 0), 64'd1);
    endtask

    initial begin
        // reset defaults
        #22;
        chk("rst_outs", all_outs(), 64'd0);
        chk("rst_credits", 64'(dut.credits_q), 64'd4);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        @(posedge i_clk); #1; i_rst_n = 1'b1;
        step(); step();
        chk("post_rst_outs", all_outs(), 64'd0);

        // nominal job
        i_credit_ret = 1'b1;
        start_job(4'd4, 4'd4, 4'd6, 2'd3, 1'b1, 16'd8, 12'h010, 12'h200);
        wait_done("nom", 40);
        chk("nom_rd_cnt", 64'(rd_cyc.size()), 64'd8);
        chk("nom_wr_cnt", 64'(wr_cyc.size()), 64'd8);
        for (int i = 0; i < 8 && i < rd_cyc.size() && i < wr_cyc.size(); i++) begin
            chk($sformatf("nom_rd_addr%0d", i), 64'(rd_addr_q[i]), 64'(12'h010 + i));
            chk($sformatf("nom_rd_cyc%0d", i), 64'(rd_cyc[i]), 64'(3 + i));
            chk($sformatf("nom_wr_addr%0d", i), 64'(wr_addr_q[i]), 64'(12'h200 + i));
            chk($sformatf("nom_wr_cyc%0d", i), 64'(wr_cyc[i]), 64'(5 + i));
        end
        chk("nom_done_n", 64'(done_n), 64'd1);
        chk("nom_done_cyc", 64'(done_cyc), 64'd14);
        chk("nom_err", 64'(err_at_done), 64'd0);
        chk("nom_cfg_stable", 64'(cfg_chg), 64'd0);
        chk("nom_round_mode", 64'(o_round_mode), 64'd1);
        chk("nom_shift_en", 64'(o_shift_en), 64'd1);
        chk("nom_credits", 64'(dut.credits_q), 64'd4);

        // illegal config
        start_job(4'd1, 4'd2, 4'd5, 2'd0, 1'b0, 16'd4, 12'h000, 12'h000);
        wait_done("ill", 20);
        chk("ill_rd_cnt", 64'(rd_cyc.size()), 64'd0);
        chk("ill_done_cyc", 64'(done_cyc), 64'd2);
        chk("ill_cfg_err", 64'(err_at_done), 64'd1);

        // zero rows
        start_job(4'd3, 4'd3, 4'd6, 2'd0, 1'b0, 16'd0, 12'h040, 12'h080);
        wait_done("zero", 20);
        chk("zero_rd_cnt", 64'(rd_cyc.size()), 64'd0);
        chk("zero_done_cyc", 64'(done_cyc), 64'd1);
        chk("zero_cfg_err", 64'(err_at_done), 64'd0);
        chk("zero_round_mode", 64'(o_round_mode), 64'd0);

        // source address wrap
        start_job(4'd2, 4'd2, 4'd4, 2'd1, 1'b1, 16'd4, 12'hFFE, 12'h100);
        wait_done("wrap", 40);
        chk("wrap_rd_cnt", 64'(rd_cyc.size()), 64'd4);
        if (rd_addr_q.size() == 4) begin
            chk("wrap_a0", 64'(rd_addr_q[0]), 64'h0FFE);
            chk("wrap_a1", 64'(rd_addr_q[1]), 64'h0FFF);
            chk("wrap_a2", 64'(rd_addr_q[2]), 64'h0000);
            chk("wrap_a3", 64'(rd_addr_q[3]), 64'h0001);
        end

        // credit stall
        i_credit_ret = 1'b0;
        start_job(4'd4, 4'd4, 4'd6, 2'd1, 1'b0, 16'd10, 12'h020, 12'h400);
        while (done_n == 0 && cyc < 80) begin
            i_credit_ret = (cyc == 20) || (cyc >= 23);
            if (cyc == 20) chk("stall_rd_at20", 64'(rd_cyc.size()), 64'd4);
            if (cyc == 26) chk("stall_credits_hold", 64'(dut.credits_q), 64'd1);
            step();
        end
        chk("stall_done_seen", 64'(done_n != 0), 64'd1);
        chk("stall_rd_cnt", 64'(rd_cyc.size()), 64'd10);
        for (int i = 0; i < 10 && i < rd_cyc.size(); i++)
            chk($sformatf("stall_rd_cyc%0d", i), 64'(rd_cyc[i]), 64'(exp_stall[i]));

        // abort mid-run
        i_credit_ret = 1'b1;
        start_job(4'd4, 4'd4, 4'd6, 2'd0, 1'b1, 16'd16, 12'h100, 12'h300);
        while (cyc < 8) step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        wait_done("abt", 40);
        chk("abt_rd_cnt", 64'(rd_cyc.size()), 64'd5);
        chk("abt_wr_cnt", 64'(wr_cyc.size()), 64'd5);
        if (wr_addr_q.size() == 5) chk("abt_last_wr", 64'(wr_addr_q[4]), 64'h304);
        chk("abt_aborted", 64'(ab_at_done), 64'd1);
        start_job(4'd4, 4'd4, 4'd6, 2'd0, 1'b1, 16'd2, 12'h500, 12'h600);
        wait_done("post_abt", 40);
        chk("post_abt_rd_cnt", 64'(rd_cyc.size()), 64'd2);
        chk("post_abt_aborted", 64'(ab_at_done), 64'd0);

        // reset during RUN
        start_job(4'd4, 4'd4, 4'd6, 2'd1, 1'b1, 16'd8, 12'h010, 12'h200);
        while (cyc < 5) step();
        i_rst_n = 1'b0;
        #2;
        chk("midrst_outs", all_outs(), 64'd0);
        step(); step();
        i_rst_n = 1'b1;
        repeat (20) step();
        chk("midrst_no_done", 64'(done_n), 64'd0);
        chk("midrst_credits", 64'(dut.credits_q), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
